spi_master_param: RTL

Parametrised SPI master supporting all four CPOL/CPHA modes, a configurable word width and SCLK divider, and multi-word transactions under one chip-select assertion. A valid/ready word interface feeds it; received words come back as a one-cycle strobe. It sits between protocol engines (flash, ADC and display controllers) and the SPI pins, and replaces the fixed mode-0, 8-bit, divide-by-4 master.

---
 rtl/spi_master_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master (CPOL/CPHA modes, DATA_W bits, CLK_DIV half-period, multi-word CS).
// Optional SPI_MASTER_LSB_FIRST_EN adds the lsb_first input for bit-0-first transfers.
`timescale 1ns/1ps
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  input  logic              spi_miso,
  output logic              spi_sclk,
  output logic              spi_cs,
  output logic              spi_mosi
);
  localparam int EW = $clog2(2*DATA_W+1);
  localparam int DW = $clog2(CLK_DIV+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [EW-1:0] edges;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next;
  logic pol, pha, last, lsb, ld_lsb, accept, div_done, lead, do_edge, sample, shift, fin;
`ifdef SPI_MASTER_LSB_FIRST_EN
  always_ff @(posedge sys_clk)
    if (sys_rst) lsb <= 1'b0;
    else if (accept && state == IDLE) lsb <= lsb_first;
  assign ld_lsb = state == IDLE ? lsb_first : lsb;
`else
  assign lsb = 1'b0;
  assign ld_lsb = 1'b0;
`endif
  // edges counts SCLK edges already issued for the current word; the next edge is leading when it is even
  always_comb begin
    tx_ready = state == IDLE || state == WAIT;
    busy = state != IDLE;
    accept = tx_valid && tx_ready;
    div_done = div == DW'(CLK_DIV-1);
    lead = ~edges[0];
    do_edge = div_done && (state == SETUP || (state == XFER && edges != LAST_EDGE));
    sample = do_edge && (lead ^ pha);
    shift = do_edge && (pha ? lead && edges != '0 : !lead && edges != LAST_EDGE - 1'b1);
    fin = sample && edges >= LAST_EDGE - EW'(2);
    rx_next = lsb ? {spi_miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], spi_miso};
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      div <= '0;
      edges <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      pol <= 1'b0;
      pha <= 1'b0;
      last <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      spi_sclk <= 1'b0;
      spi_cs <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= fin;
      if (fin) rx_data <= rx_next;
      if (sample) rx_sr <= rx_next;
      if (do_edge) begin
        spi_sclk <= ~spi_sclk;
        edges <= edges + 1'b1;
      end
      if (shift) begin
        tx_sr <= lsb ? tx_sr >> 1 : tx_sr << 1;
        spi_mosi <= lsb ? tx_sr[1] : tx_sr[DATA_W-2];
      end
      div <= (state == SETUP || state == XFER || state == HOLD) && !div_done ? div + 1'b1 : '0;
      if (accept) begin
        tx_sr <= tx_data;
        last <= tx_last;
        edges <= '0;
        spi_mosi <= ld_lsb ? tx_data[0] : tx_data[DATA_W-1];
      end
      // after the last edge XFER waits one more half-period so the final SCLK level lasts CLK_DIV cycles
      case (state)
        IDLE: if (accept) begin
          state <= SETUP;
          spi_cs <= 1'b0;
          pol <= cpol;
          pha <= cpha;
          spi_sclk <= cpol;
        end
        SETUP: if (div_done) state <= XFER;
        XFER: if (div_done && edges == LAST_EDGE) state <= last ? HOLD : WAIT;
        WAIT: if (accept) state <= XFER;
        HOLD: if (div_done) begin
          state <= IDLE;
          spi_cs <= 1'b1;
          spi_mosi <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
